music_player_ctrl: RTL and testbench

MUSIC_PLAYER_CTRL -- requirements
Module: music_player_ctrl

---
 rtl/music_pkg.sv | 57 +++++
 rtl/music_tone_gen.sv | 32 +++
 rtl/music_player_ctrl.sv | 159 +++++++++++++++
 tb/tb_music_player_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// music_pkg -- shared definitions for the music player controller.
//   NOTE_W / ADDR_W : widths of the note code and of the ROM address
//   state_t         : controller FSM states
//   HALF_PERIOD     : half-period table (in clocks) for the 12 MHz default clock
//   calc_half_period: the same table for any clock, used for elaboration-time
//                     constants only
// Note codes: 0 = rest, 1-7 low do..ti, 8-14 middle, 15-21 high. Pitches are
// equal temperament from low do = 262 Hz, rounded to the nearest Hz.
package music_pkg;

  localparam int NOTE_W         = 5;
  localparam int ADDR_W         = 8;
  localparam int NUM_NOTES      = 22;
  localparam int DEFAULT_CLK_HZ = 12_000_000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    GAP  = 2'd3
  } state_t;

  // DEFAULT_CLK_HZ / (2 * f_n); entry 0 (rest) is unused.
  localparam logic [15:0] HALF_PERIOD [NUM_NOTES] = '{
    16'd0,
    16'd22900, 16'd20408, 16'd18181, 16'd17142, 16'd15267, 16'd13605, 16'd12121,
    16'd11450, 16'd10204, 16'd9090,  16'd8583,  16'd7643,  16'd6810,  16'd6066,
    16'd5725,  16'd5102,  16'd4545,  16'd4288,  16'd3821,  16'd3403,  16'd3033
  };

  function automatic int unsigned note_freq_hz(input int unsigned code);
    case (code)
      1:  return 262;  2:  return 294;  3:  return 330;  4:  return 350;
      5:  return 393;  6:  return 441;  7:  return 495;
      8:  return 524;  9:  return 588;  10: return 660;  11: return 699;
      12: return 785;  13: return 881;  14: return 989;
      15: return 1048; 16: return 1176; 17: return 1320; 18: return 1399;
      19: return 1570; 20: return 1763; 21: return 1978;
      default: return 0;
    endcase
  endfunction

  // Rest/illegal codes and very slow clocks are clamped to 1 so the tone
  // counter compare value (half_period - 1) never underflows.
  function automatic logic [15:0] calc_half_period(input int unsigned clk_hz,
                                                   input int unsigned code);
    int unsigned f;
    int unsigned hp;
    f = note_freq_hz(code);
    if (f == 0) return 16'd1;
    hp = clk_hz / (2 * f);
    if (hp == 0) hp = 1;
    if (hp > 65535) hp = 65535;
    return 16'(hp);
  endfunction

endpackage

// File: rtl/music_tone_gen.sv
// music_tone_gen -- square-wave generator for one note.
//   clk, rst    : clock, synchronous active-high reset
//   en          : advance the half-period counter this cycle
//   clr         : clear counter and tone (takes effect over en)
//   half_period : clocks per half wave of the current note
//   tone        : raw square wave, toggles when the counter hits half_period-1
module music_tone_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic [15:0] half_period,
  output logic        tone
);

  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (en) begin
      if (cnt >= half_period - 16'd1) begin
        cnt  <= '0;
        tone <= ~tone;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/music_player_ctrl.sv
// music_player_ctrl -- plays SONG_LEN note codes from an external
// combinational ROM on a square-wave buzzer.
//   clk, rst  : clock, synchronous active-high reset
//   start     : level, starts a song from IDLE (ignored elsewhere)
//   stop      : aborts playback to IDLE; wins over start and pause
//   pause     : level, freezes FSM, address and counters; mutes beep
//   rom_addr  : address of the current ROM entry
//   rom_data  : note code at rom_addr
//   beep      : buzzer drive
//   playing   : high in LOAD, PLAY and GAP
//   done      : one-cycle pulse after the last entry finishes
//   fsm_state : current FSM state, for debug/observation
// Each entry is 1 LOAD cycle, NOTE_CYCLES-GAP_CYCLES PLAY cycles and
// GAP_CYCLES silent GAP cycles. Define MUSIC_PLAYER_LOOP_EN to restart the
// song at entry 0 after the last entry instead of returning to IDLE.
module music_player_ctrl
  import music_pkg::*;
#(
  parameter int CLK_HZ      = 12_000_000,
  parameter int NOTE_CYCLES = 3_000_000,
  parameter int GAP_CYCLES  = 300_000,
  parameter int SONG_LEN    = 84
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [NOTE_W-1:0] rom_data,
  output logic              beep,
  output logic              playing,
  output logic              done,
  output state_t            fsm_state
);

  localparam int DUR_W      = (NOTE_CYCLES > 1) ? $clog2(NOTE_CYCLES) : 1;
  localparam int PLAY_LAST_I = NOTE_CYCLES - GAP_CYCLES - 1;
  localparam int GAP_LAST_I  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [DUR_W-1:0]  PLAY_LAST = DUR_W'(PLAY_LAST_I);
  localparam logic [DUR_W-1:0]  GAP_LAST  = DUR_W'(GAP_LAST_I);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

  state_t             state, state_n;
  logic [ADDR_W-1:0]  addr_n;
  logic [DUR_W-1:0]   dur_cnt, dur_n;
  logic [NOTE_W-1:0]  note_q, note_n;
  logic               done_n;
  logic               entry_end;

  // Constant half-period lookup for this clock; codes 22-31 map to 1.
  logic [15:0] hp_rom [32];
  for (genvar g = 0; g < 32; g++) begin : g_hp
    assign hp_rom[g] = calc_half_period(CLK_HZ, g);
  end

  logic note_ok;
  logic tone;
  logic tone_en;
  logic tone_clr;

  assign note_ok = (note_q != '0) && (note_q <= NOTE_W'(NUM_NOTES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rom_addr <= '0;
      dur_cnt  <= '0;
      note_q   <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      rom_addr <= addr_n;
      dur_cnt  <= dur_n;
      note_q   <= note_n;
      done     <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    addr_n    = rom_addr;
    dur_n     = dur_cnt;
    note_n    = note_q;
    done_n    = 1'b0;
    entry_end = 1'b0;
    if (stop) begin
      state_n = IDLE;
      addr_n  = '0;
      dur_n   = '0;
      note_n  = '0;
    end else if (!pause) begin
      case (state)
        IDLE: begin
          if (start) begin
            state_n = LOAD;
            addr_n  = '0;
          end
        end
        LOAD: begin
          note_n  = rom_data;
          dur_n   = '0;
          state_n = PLAY;
        end
        PLAY: begin
          if (dur_cnt == PLAY_LAST) begin
            dur_n = '0;
            if (GAP_CYCLES == 0) entry_end = 1'b1;
            else                 state_n   = GAP;
          end else begin
            dur_n = dur_cnt + 1'b1;
          end
        end
        GAP: begin
          if (dur_cnt == GAP_LAST) begin
            dur_n     = '0;
            entry_end = 1'b1;
          end else begin
            dur_n = dur_cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase

      if (entry_end) begin
        if (rom_addr == LAST_ADDR) begin
          done_n = 1'b1;
          addr_n = '0;
`ifdef MUSIC_PLAYER_LOOP_EN
          state_n = LOAD;
`else
          state_n = IDLE;
`endif
        end else begin
          addr_n  = rom_addr + 1'b1;
          state_n = LOAD;
        end
      end
    end
  end

  // Counter restarts at every LOAD so each entry begins on a low half-wave.
  assign tone_clr = (state == LOAD) || (state == IDLE);
  assign tone_en  = (state == PLAY) && !pause && !stop;

  music_tone_gen u_tone (
    .clk         (clk),
    .rst         (rst),
    .en          (tone_en),
    .clr         (tone_clr),
    .half_period (hp_rom[note_q]),
    .tone        (tone)
  );

  assign beep      = tone && (state == PLAY) && !pause && note_ok;
  assign playing   = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_music_player_ctrl.sv
// tb_music_player_ctrl -- self-checking bench for music_player_ctrl.
// Scenarios are written as tables of segments {inputs, cycle count, expected
// outputs}; each driven cycle pushes its expected {rom_addr, playing, done,
// beep} word to a queue that the negedge monitor pops and compares.
// CLK_HZ = 3144 makes code 8 (524 Hz) a half period of 3 clocks and code 12
// (785 Hz) a half period of 2 clocks.
module tb_music_player_ctrl;
  import music_pkg::*;

  localparam int W = 11;
`ifdef MUSIC_PLAYER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst, start, stop, pause;
  logic [7:0] rom_addr;
  logic [4:0] rom_data;
  logic beep, playing, done;
  state_t fsm_state;

  always #5 clk = ~clk;

  logic [4:0] rom_mem [3];
  assign rom_data = (rom_addr < 8'd3) ? rom_mem[rom_addr[1:0]] : 5'd0;

  music_player_ctrl #(
    .CLK_HZ      (3144),
    .NOTE_CYCLES (20),
    .GAP_CYCLES  (4),
    .SONG_LEN    (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .beep      (beep),
    .playing   (playing),
    .done      (done),
    .fsm_state (fsm_state)
  );

  // vector table
  typedef struct {
    logic       st;
    logic       sp;
    logic       pa;
    logic       rs;
    int         n;
    logic [7:0] addr;
    logic       pl;
    logic       dn;
    int         hp;   // 0 = beep must stay low; else expected half period
    int         ph;   // PLAY cycles already elapsed when the segment starts
  } seg_t;

  seg_t segs[$];

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           tag_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           scen     = 0;

  function automatic void add_seg(input logic st, input logic sp, input logic pa,
                                  input logic rs, input int n, input int addr,
                                  input logic pl, input logic dn, input int hp,
                                  input int ph);
    seg_t s;
    s.st = st; s.sp = sp; s.pa = pa; s.rs = rs; s.n = n;
    s.addr = 8'(addr); s.pl = pl; s.dn = dn; s.hp = hp; s.ph = ph;
    segs.push_back(s);
  endfunction

  // LOAD + 16 PLAY + 4 GAP for one undisturbed entry
  function automatic void add_entry(input int addr, input int hp);
    add_seg(0, 0, 0, 0, 1,  addr, 1, 0, 0,  0);
    add_seg(0, 0, 0, 0, 16, addr, 1, 0, hp, 0);
    add_seg(0, 0, 0, 0, 4,  addr, 1, 0, 0,  0);
  endfunction

  // driver
  task automatic run_segs();
    for (int i = 0; i < segs.size(); i++) begin
      for (int k = 0; k < segs[i].n; k++) begin
        logic b;
        int   kk;
        @(posedge clk);
        #1;
        start = segs[i].st;
        stop  = segs[i].sp;
        pause = segs[i].pa;
        rst   = segs[i].rs;
        kk = segs[i].ph + k;
        b  = (segs[i].hp != 0) && (((kk / segs[i].hp) % 2) == 1);
        exp_q.push_back({segs[i].addr, segs[i].pl, segs[i].dn, b});
        tag_q.push_back(scen * 100000 + i * 1000 + k);
      end
    end
    segs.delete();
  endtask

  // monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] g;
      int           t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      g = {rom_addr, playing, done, beep};
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL out s%0d/seg%0d/cyc%0d: got addr=%0d playing=%b done=%b beep=%b, expected addr=%0d playing=%b done=%b beep=%b",
                 t / 100000, (t / 1000) % 100, t % 1000,
                 g[10:3], g[2], g[1], g[0], e[10:3], e[2], e[1], e[0]);
      end
    end
  end

  task automatic check_idle(input string name);
    @(negedge clk);
    n_checks++;
    if (fsm_state !== IDLE) begin
      n_fail++;
      $display("FAIL %s: got state=%0d, expected state=%0d", name, fsm_state, IDLE);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    rom_mem[0] = 5'd8; rom_mem[1] = 5'd0; rom_mem[2] = 5'd12;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, then a full song; start during entry 1 is ignored.
    scen = 1;
    add_seg(0, 0, 0, 0, 3, 0, 0, 0, 0, 0);
    add_seg(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add_entry(0, 3);
    add_seg(0, 0, 0, 0, 1,  1, 1, 0, 0, 0);
    add_seg(1, 0, 0, 0, 16, 1, 1, 0, 0, 0);
    add_seg(0, 0, 0, 0, 4,  1, 1, 0, 0, 0);
    add_entry(2, 2);
    add_seg(0, LOOP, 0, 0, 1, 0, LOOP, 1, 0, 0);
    add_seg(0, 0, 0, 0, 3, 0, 0, 0, 0, 0);
    run_segs();
    check_idle("idle_after_song");

    // Rest and out-of-range codes stay silent; stop+start+pause mid-GAP.
    scen = 2;
    rom_mem[0] = 5'd0; rom_mem[1] = 5'd25; rom_mem[2] = 5'd12;
    add_seg(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add_entry(0, 0);
    add_seg(0, 0, 0, 0, 1,  1, 1, 0, 0, 0);
    add_seg(0, 0, 0, 0, 16, 1, 1, 0, 0, 0);
    add_seg(0, 0, 0, 0, 2,  1, 1, 0, 0, 0);
    add_seg(1, 1, 1, 0, 1,  1, 1, 0, 0, 0);
    add_seg(0, 0, 0, 0, 5,  0, 0, 0, 0, 0);
    run_segs();
    check_idle("idle_after_stop");

    // 10-cycle pause at PLAY cycle 6 of entry 0: song ends 10 cycles later.
    scen = 3;
    rom_mem[0] = 5'd8; rom_mem[1] = 5'd0; rom_mem[2] = 5'd12;
    add_seg(1, 0, 0, 0, 1,  0, 0, 0, 0, 0);
    add_seg(0, 0, 0, 0, 1,  0, 1, 0, 0, 0);
    add_seg(0, 0, 0, 0, 6,  0, 1, 0, 3, 0);
    add_seg(0, 0, 1, 0, 10, 0, 1, 0, 0, 0);
    add_seg(0, 0, 0, 0, 10, 0, 1, 0, 3, 6);
    add_seg(0, 0, 0, 0, 4,  0, 1, 0, 0, 0);
    add_entry(1, 0);
    add_entry(2, 2);
    add_seg(0, LOOP, 0, 0, 1, 0, LOOP, 1, 0, 0);
    add_seg(0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
    run_segs();

    // Reset in the middle of entry 1's GAP.
    scen = 4;
    add_seg(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add_entry(0, 3);
    add_seg(0, 0, 0, 0, 1,  1, 1, 0, 0, 0);
    add_seg(0, 0, 0, 0, 16, 1, 1, 0, 0, 0);
    add_seg(0, 0, 0, 0, 2,  1, 1, 0, 0, 0);
    add_seg(0, 0, 0, 1, 1,  1, 1, 0, 0, 0);
    add_seg(0, 0, 0, 0, 3,  0, 0, 0, 0, 0);
    run_segs();
    check_idle("idle_after_rst");

    repeat (2) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
